// File: rtl/fc_output_check_if.sv
// rtl/fc_output_check_if.sv - result bundle between the redundant encryption cores, the checker and its consumer
interface fc_output_check_if #(
    parameter int y = 40
);
    logic           start;
    logic [y-1:0]   ct_a;
    logic [127:0]   tag_a;
    logic           ready_a;
    logic [y-1:0]   ct_b;
    logic [127:0]   tag_b;
    logic           ready_b;
    logic           out_ready;
    logic [y-1:0]   cipher_text;
    logic [127:0]   tag;
    logic           out_valid;
    logic           fault;
    logic           busy;

    modport master (
        output start, ct_a, tag_a, ready_a, ct_b, tag_b, ready_b, out_ready,
        input  cipher_text, tag, out_valid, fault, busy
    );

    modport slave (
        input  start, ct_a, tag_a, ready_a, ct_b, tag_b, ready_b, out_ready,
        output cipher_text, tag, out_valid, fault, busy
    );
endinterface

// File: rtl/fc_output_check.sv
// rtl/fc_output_check.sv - compares two redundant encryption results; FC_CHECK_TIMEOUT_EN adds the WAIT timeout
module fc_output_check #(
    parameter int y       = 40,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    fc_output_check_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CMP, S_OUT, S_FAULT} state_t;

    state_t         state_q, state_d;
    logic           cap_a_q, cap_a_d, cap_b_q, cap_b_d;
    logic [y-1:0]   ct_a_q, ct_a_d, ct_b_q, ct_b_d;
    logic [127:0]   tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic [y-1:0]   cipher_text_q, cipher_text_d;
    logic [127:0]   tag_q, tag_d;
    logic           out_valid_q, out_valid_d;
    logic           fault_q, fault_d;
    logic           busy_q, busy_d;
    logic           cap_a_now, cap_b_now;
    logic           enter_idle, enter_fault;

`ifdef FC_CHECK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // TIMEOUT has no effect without the wait counter
    if (TIMEOUT < 2) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d       = state_q;
        cap_a_d       = cap_a_q;
        cap_b_d       = cap_b_q;
        ct_a_d        = ct_a_q;
        ct_b_d        = ct_b_q;
        tag_a_d       = tag_a_q;
        tag_b_d       = tag_b_q;
        cipher_text_d = cipher_text_q;
        tag_d         = tag_q;
        out_valid_d   = out_valid_q;
        fault_d       = fault_q;
        busy_d        = busy_q;
        enter_idle    = 1'b0;
        enter_fault   = 1'b0;
`ifdef FC_CHECK_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        // capture flags as they will be after this cycle's sampling
        cap_a_now = cap_a_q | bus.ready_a;
        cap_b_now = cap_b_q | bus.ready_b;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WAIT;
                    cap_a_d = 1'b0;
                    cap_b_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef FC_CHECK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (bus.ready_a && !cap_a_q) begin
                    ct_a_d  = bus.ct_a;
                    tag_a_d = bus.tag_a;
                    cap_a_d = 1'b1;
                end
                if (bus.ready_b && !cap_b_q) begin
                    ct_b_d  = bus.ct_b;
                    tag_b_d = bus.tag_b;
                    cap_b_d = 1'b1;
                end
                if (cap_a_now && cap_b_now) begin
                    state_d = S_CMP;
                end
`ifdef FC_CHECK_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    enter_fault = 1'b1;
                end
                cnt_d = cnt_q + CNT_W'(1);
`endif
            end
            S_CMP: begin
                if ({ct_a_q, tag_a_q} == {ct_b_q, tag_b_q}) begin
                    state_d       = S_OUT;
                    out_valid_d   = 1'b1;
                    cipher_text_d = ct_a_q;
                    tag_d         = tag_a_q;
                end else begin
                    enter_fault = 1'b1;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    enter_idle = 1'b1;
                end
            end
            S_FAULT: begin
            end
            default: begin
                enter_fault = 1'b1;
            end
        endcase

        // leaving a transaction never keeps a partial or released result
        if (enter_idle || enter_fault) begin
            state_d       = enter_fault ? S_FAULT : S_IDLE;
            cap_a_d       = 1'b0;
            cap_b_d       = 1'b0;
            ct_a_d        = '0;
            ct_b_d        = '0;
            tag_a_d       = '0;
            tag_b_d       = '0;
            cipher_text_d = '0;
            tag_d         = '0;
            out_valid_d   = 1'b0;
            fault_d       = enter_fault;
            busy_d        = enter_fault;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cap_a_q       <= 1'b0;
            cap_b_q       <= 1'b0;
            ct_a_q        <= '0;
            ct_b_q        <= '0;
            tag_a_q       <= '0;
            tag_b_q       <= '0;
            cipher_text_q <= '0;
            tag_q         <= '0;
            out_valid_q   <= 1'b0;
            fault_q       <= 1'b0;
            busy_q        <= 1'b0;
`ifdef FC_CHECK_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cap_a_q       <= cap_a_d;
            cap_b_q       <= cap_b_d;
            ct_a_q        <= ct_a_d;
            ct_b_q        <= ct_b_d;
            tag_a_q       <= tag_a_d;
            tag_b_q       <= tag_b_d;
            cipher_text_q <= cipher_text_d;
            tag_q         <= tag_d;
            out_valid_q   <= out_valid_d;
            fault_q       <= fault_d;
            busy_q        <= busy_d;
`ifdef FC_CHECK_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign bus.cipher_text = cipher_text_q;
    assign bus.tag         = tag_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.fault       = fault_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_fc_output_check.sv
// tb/tb_fc_output_check.sv - self-checking bench for fc_output_check
module tb_fc_output_check;
    localparam int Y  = 40;
    localparam int TO = 16;
`ifdef FC_CHECK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [Y-1:0] CT0  = 40'h0123456789;
    localparam logic [Y-1:0] CT1  = 40'hFEDCBA9876;
    localparam logic [127:0] TAG0 = {16{8'hA5}};
    localparam logic [127:0] TAG1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    typedef struct {
        int           ta;
        int           tb;
        logic [Y-1:0] cta;
        logic [127:0] tga;
        logic [Y-1:0] ctb;
        logic [127:0] tgb;
        bit           level;
        int           rdy_from;
        int           max_cyc;
        int           e_ov;
        int           e_len;
        int           e_f;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fc_output_check_if #(.y(Y)) bus ();
    fc_output_check #(.y(Y), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level prediction: cycle numbers count from the start edge.
    function automatic void model(input int ta, input int tb, input bit eq, input int rdy_from,
                                  output int ov, output int len, output int f);
        int done;
        done = (ta > 0 && tb > 0) ? ((ta > tb) ? ta : tb) : -1;
        ov = -1; len = 0; f = -1;
        if (TO_EN && (done < 0 || done > TO)) begin
            f = TO + 1;
            return;
        end
        if (done < 0) return;
        if (!eq) begin
            f = done + 2;
        end else begin
            ov  = done + 2;
            len = ((rdy_from > ov) ? rdy_from : ov) - ov + 1;
        end
    endfunction

    task automatic drive_idle();
        bus.start = 1'b0; bus.out_ready = 1'b0;
        bus.ready_a = 1'b0; bus.ready_b = 1'b0;
        bus.ct_a = '0; bus.tag_a = '0; bus.ct_b = '0; bus.tag_b = '0;
    endtask

    task automatic reset_dut();
        drive_idle();
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Entered just after a rising edge; returns at the falling edge of the last observed cycle.
    task automatic run_txn(input vec_t v, output int ov_cyc, output int ov_len, output int f_cyc,
                           output int busy_lo, output logic [167:0] data);
        ov_cyc = -1; ov_len = 0; f_cyc = -1; busy_lo = 0; data = '0;
        bus.start     = 1'b1;
        bus.out_ready = (v.rdy_from <= 0);
        for (int c = 1; c <= v.max_cyc; c++) begin
            @(posedge clk);
            #1;
            bus.start     = 1'b0;
            bus.ready_a   = (v.ta > 0) && (v.level ? (c >= v.ta) : (c == v.ta));
            bus.ready_b   = (v.tb > 0) && (v.level ? (c >= v.tb) : (c == v.tb));
            bus.ct_a      = (c == v.ta) ? v.cta : ~v.cta;
            bus.tag_a     = (c == v.ta) ? v.tga : ~v.tga;
            bus.ct_b      = (c == v.tb) ? v.ctb : ~v.ctb;
            bus.tag_b     = (c == v.tb) ? v.tgb : ~v.tgb;
            bus.out_ready = (c >= v.rdy_from);
            @(negedge clk);
            if (bus.out_valid) begin
                if (ov_cyc < 0) begin
                    ov_cyc = c;
                    data   = {bus.cipher_text, bus.tag};
                end
                ov_len++;
            end
            if (bus.fault && f_cyc < 0) f_cyc = c;
            if (f_cyc >= 0 || (ov_cyc >= 0 && !bus.out_valid)) break;
            if (!bus.busy) busy_lo++;
        end
        drive_idle();
    endtask

    task automatic txn_and_check(input string nm, input vec_t v);
        int ov_cyc, ov_len, f_cyc, busy_lo;
        logic [167:0] data;
        run_txn(v, ov_cyc, ov_len, f_cyc, busy_lo, data);
        check_int({nm, " out_valid cycle"}, ov_cyc, v.e_ov);
        check_int({nm, " fault cycle"}, f_cyc, v.e_f);
        check_int({nm, " busy low while active"}, busy_lo, 0);
        if (v.e_ov >= 0) begin
            check_int({nm, " out_valid length"}, ov_len, v.e_len);
            check_vec({nm, " released data"}, data, {v.cta, v.tga});
            check_vec({nm, " idle after accept"}, {bus.out_valid, bus.busy, bus.fault, bus.cipher_text, bus.tag}, '0);
        end else if (v.e_f >= 0) begin
            check_vec({nm, " fault outputs"}, {bus.fault, bus.busy, bus.out_valid, bus.cipher_text, bus.tag},
                      {3'b110, 168'b0});
            @(posedge clk); #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_vec({nm, " fault sticky after start"}, {bus.fault, bus.busy, bus.out_valid, bus.cipher_text, bus.tag},
                      {3'b110, 168'b0});
        end else begin
            check_vec({nm, " still waiting"}, {bus.busy, bus.fault, bus.out_valid}, 3'b100);
        end
        if (ov_cyc >= 0 && f_cyc < 0 && !bus.busy) begin
            @(posedge clk);
            #1;
        end else begin
            reset_dut();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        vec_t v;
        logic [191:0] r;
        logic [167:0] flip;

        vt[0] = '{10, 10, CT0, TAG0, CT0, TAG0, 1'b0, 20, 60, 12, 9, -1};
        vt[1] = '{5, 30, CT1, TAG1, CT1, TAG1, 1'b0, 0, 60, TO_EN ? -1 : 32, TO_EN ? 0 : 1, TO_EN ? 17 : -1};
        vt[2] = '{4, 4, CT0, TAG0, CT0, TAG0 ^ 128'h1, 1'b0, 0, 60, -1, 0, 6};
        vt[3] = '{2, 7, CT1, TAG1, CT1 ^ 40'h80_0000_0000, TAG1, 1'b0, 0, 60, -1, 0, 9};
        vt[4] = '{1, 1, CT1, TAG0, CT1, TAG0, 1'b0, 0, 60, 3, 1, -1};
        vt[5] = '{2, 6, CT0, TAG1, CT0, TAG1, 1'b1, 0, 60, 8, 1, -1};
        vt[6] = '{9, 3, CT1, TAG0, CT1, TAG0, 1'b1, 14, 60, 11, 4, -1};
        vt[7] = '{3, TO, CT0, TAG0, CT0, TAG0, 1'b0, 0, 60, TO + 2, 1, -1};
        vt[8] = '{5, TO + 1, CT1, TAG1, CT1, TAG1, 1'b0, 0, 60,
                  TO_EN ? -1 : TO + 3, TO_EN ? 0 : 1, TO_EN ? TO + 1 : -1};
        vt[9] = '{3, 0, CT0, TAG0, CT0, TAG0, 1'b0, 0, TO_EN ? 60 : 1000, -1, 0, TO_EN ? TO + 1 : -1};

        drive_idle();
        rst = 1'b0;
        #12;
        check_vec("reset outputs", {bus.out_valid, bus.fault, bus.busy, bus.cipher_text, bus.tag}, '0);
        @(posedge clk);
        #1 rst = 1'b1;

        // asynchronous reset in the middle of WAIT
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("wait busy", int'(bus.busy), 1);
        #2 rst = 1'b0;
        #1 check_vec("async reset in wait", {bus.out_valid, bus.fault, bus.busy, bus.cipher_text, bus.tag}, '0);
        @(posedge clk); #1 rst = 1'b1;

        // start ignored in OUT, then asynchronous reset in the middle of OUT
        bus.start = 1'b1;
        bus.ct_a = CT0; bus.tag_a = TAG1; bus.ct_b = CT0; bus.tag_b = TAG1;
        @(posedge clk); #1 bus.start = 1'b0; bus.ready_a = 1'b1; bus.ready_b = 1'b1;
        @(posedge clk); #1 bus.ready_a = 1'b0; bus.ready_b = 1'b0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(negedge clk);
        check_vec("out entered", {bus.out_valid, bus.busy, bus.fault, bus.cipher_text, bus.tag}, {3'b110, CT0, TAG1});
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        check_vec("out held past start", {bus.out_valid, bus.busy, bus.fault, bus.cipher_text, bus.tag}, {3'b110, CT0, TAG1});
        #2 rst = 1'b0;
        #1 check_vec("async reset in out", {bus.out_valid, bus.fault, bus.busy, bus.cipher_text, bus.tag}, '0);
        drive_idle();
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            txn_and_check($sformatf("vec%0d", i), vt[i]);
        end

        for (int i = 0; i < 25; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            v.ta = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            v.tb = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            v.cta = r[167:128];
            v.tga = r[127:0];
            flip = '0;
            if ($urandom_range(0, 1) == 1) flip[$urandom_range(0, 167)] = 1'b1;
            {v.ctb, v.tgb} = r[167:0] ^ flip;
            v.level    = ($urandom_range(0, 1) == 1);
            v.rdy_from = int'($urandom_range(0, 30));
            v.max_cyc  = 60;
            model(v.ta, v.tb, (flip == '0), v.rdy_from, v.e_ov, v.e_len, v.e_f);
            txn_and_check($sformatf("rand%0d", i), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
